// File: rtl/ex_mem_ctrl.sv
// EX/MEM stage register and data-memory handshake controller: non-memory ops pass in one cycle,
// memory ops stall the front end while BUSY until ack, misalignment or a 15-cycle timeout.
module ex_mem_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic [31:0] alu_outE,
   input  logic [31:0] write_dataE,
   input  logic [4:0]  r3_addrE,
   input  logic [5:0]  opE,
   input  logic        validE,
   input  logic        flushE,
   output logic        RegWriteM,
   output logic        MemtoRegM,
   output logic [31:0] alu_outM,
   output logic [4:0]  r3_addrM,
   output logic [5:0]  opM,
   output logic [31:0] doutbM,
   output logic        stallM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        dmem_err
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   typedef struct packed {
      logic        valid;
      logic        regWrite;
      logic        memtoReg;
      logic        memWrite;
      logic [31:0] aluOut;
      logic [31:0] wdata;
      logic [4:0]  r3Addr;
      logic [5:0]  op;
   } exMem_t;

   // Counter value during the 15th BUSY cycle; it becomes 15 on that cycle's closing edge.
   localparam logic [3:0] TimeoutLast = 4'd14;

   state_t      state;
   state_t      nextState;
   exMem_t      stage;
   logic [3:0]  toCnt;
   logic        misErr;
   logic [31:0] doutb;

   logic        capValid;
   logic        isMemE;
   logic        misalE;
   logic        startAcc;
   logic        misalHit;
   logic        timeoutHit;

   assign capValid   = validE & ~flushE;
   assign isMemE     = MemtoRegE | MemWriteE;
   assign misalE     = |alu_outE[1:0];
   assign startAcc   = capValid & isMemE & ~misalE;
   assign misalHit   = capValid & isMemE & misalE;
   assign timeoutHit = (state == BUSY) & ~dmem_ack & (toCnt == TimeoutLast);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (startAcc) nextState = BUSY;
         BUSY: if (dmem_ack || timeoutHit) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
      end else if (state == IDLE) begin
         stage.valid    <= capValid & ~misalHit;
         stage.regWrite <= RegWriteE;
         stage.memtoReg <= MemtoRegE;
         stage.memWrite <= MemWriteE;
         stage.aluOut   <= alu_outE;
         stage.wdata    <= write_dataE;
         stage.r3Addr   <= r3_addrE;
         stage.op       <= opE;
      end else if (timeoutHit) begin
         stage.valid <= 1'b0;
      end
   end

   // Held at zero in IDLE so every BUSY entry starts counting from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         toCnt <= 4'd0;
      end else if (state == IDLE) begin
         toCnt <= 4'd0;
      end else if (!dmem_ack) begin
         toCnt <= toCnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misErr <= 1'b0;
      end else begin
         misErr <= (state == IDLE) & misalHit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         doutb <= 32'd0;
      end else if ((state == BUSY) && dmem_ack) begin
         doutb <= dmem_rdata;
      end
   end

   always_comb begin
      stallM     = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'd0;
      dmem_wdata = 32'd0;
      RegWriteM  = 1'b0;
      MemtoRegM  = 1'b0;
      dmem_err   = misErr | timeoutHit;
      unique case (state)
         BUSY: begin
            stallM     = 1'b1;
            dmem_req   = 1'b1;
            dmem_we    = stage.memWrite;
            dmem_addr  = stage.aluOut;
            dmem_wdata = stage.wdata;
         end
         default: begin
            RegWriteM = stage.regWrite & stage.valid;
            MemtoRegM = stage.memtoReg & stage.valid;
         end
      endcase
   end

   assign alu_outM = stage.aluOut;
   assign r3_addrM = stage.r3Addr;
   assign opM      = stage.op;
   assign doutbM   = doutb;

endmodule

// File: tb/tb_ex_mem_ctrl.sv
// Directed and randomized bench for ex_mem_ctrl against a transaction-level timeline model.
module tb_ex_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWriteE, MemtoRegE, MemWriteE;
   logic [31:0] alu_outE, write_dataE;
   logic [4:0]  r3_addrE;
   logic [5:0]  opE;
   logic        validE, flushE;
   logic        RegWriteM, MemtoRegM;
   logic [31:0] alu_outM;
   logic [4:0]  r3_addrM;
   logic [5:0]  opM;
   logic [31:0] doutbM;
   logic        stallM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        dmem_err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expDout;

   ex_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .alu_outE(alu_outE), .write_dataE(write_dataE), .r3_addrE(r3_addrE), .opE(opE),
      .validE(validE), .flushE(flushE),
      .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .alu_outM(alu_outM),
      .r3_addrM(r3_addrM), .opM(opM), .doutbM(doutbM), .stallM(stallM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .dmem_err(dmem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic driveRandomE();
      RegWriteE   = 1'($urandom);
      MemtoRegE   = 1'($urandom);
      MemWriteE   = 1'($urandom);
      alu_outE    = $urandom;
      write_dataE = $urandom;
      r3_addrE    = 5'($urandom);
      opE         = 6'($urandom);
      validE      = 1'($urandom);
      flushE      = 1'($urandom);
   endtask

   // Bubble filler; ack is random because an ack in IDLE must be ignored.
   task automatic driveIdle();
      driveRandomE();
      validE     = 1'b0;
      dmem_ack   = 1'($urandom);
      dmem_rdata = $urandom;
   endtask

   // One instruction: capture cycle, optional BUSY window, then the presentation cycle.
   // ackAt = BUSY cycle number carrying the ack (1..15); any other value means never acked.
   task automatic doInstr(input logic rw, input logic mtr, input logic mw,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [5:0] op,
                          input logic vld, input logic fl,
                          input int ackAt, input logic [31:0] rdata, input string tag);
      logic capV, isMem, mis, goBusy, acked, killed, expV, ackNow;
      @(negedge clk);
      RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw;
      alu_outE = addr; write_dataE = wd; r3_addrE = rd; opE = op;
      validE = vld; flushE = fl;
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      #1;
      chk({tag, ".cap_stall"}, 32'(stallM), 32'd0);
      chk({tag, ".cap_req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".cap_err"}, 32'(dmem_err), 32'd0);

      capV   = vld & ~fl;
      isMem  = mtr | mw;
      mis    = (addr[1:0] != 2'b00);
      goBusy = capV & isMem & ~mis;
      acked  = 1'b0;
      if (goBusy) begin
         for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            driveRandomE();
            ackNow     = (k == ackAt);
            dmem_ack   = ackNow;
            dmem_rdata = ackNow ? rdata : $urandom;
            #1;
            chk({tag, ".busy_stall"}, 32'(stallM), 32'd1);
            chk({tag, ".busy_req"}, 32'(dmem_req), 32'd1);
            chk({tag, ".busy_we"}, 32'(dmem_we), 32'(mw));
            chk({tag, ".busy_addr"}, dmem_addr, addr);
            chk({tag, ".busy_wdata"}, dmem_wdata, wd);
            chk({tag, ".busy_regwr"}, 32'(RegWriteM), 32'd0);
            chk({tag, ".busy_m2r"}, 32'(MemtoRegM), 32'd0);
            chk({tag, ".busy_alu"}, alu_outM, addr);
            chk({tag, ".busy_err"}, 32'(dmem_err), 32'((k == 15) && !ackNow));
            if (ackNow) begin
               acked = 1'b1;
               break;
            end
         end
      end

      @(negedge clk);
      driveIdle();
      #1;
      if (acked) expDout = rdata;
      killed = (goBusy & ~acked) | (capV & isMem & mis);
      expV   = capV & ~killed;
      chk({tag, ".out_stall"}, 32'(stallM), 32'd0);
      chk({tag, ".out_req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".out_regwr"}, 32'(RegWriteM), 32'(expV & rw));
      chk({tag, ".out_m2r"}, 32'(MemtoRegM), 32'(expV & mtr));
      chk({tag, ".out_alu"}, alu_outM, addr);
      chk({tag, ".out_r3"}, 32'(r3_addrM), 32'(rd));
      chk({tag, ".out_op"}, 32'(opM), 32'(op));
      chk({tag, ".out_dout"}, doutbM, expDout);
      chk({tag, ".out_err"}, 32'(dmem_err), 32'(capV & isMem & mis));
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, ".stall"}, 32'(stallM), 32'd0);
      chk({tag, ".req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".we"}, 32'(dmem_we), 32'd0);
      chk({tag, ".addr"}, dmem_addr, 32'd0);
      chk({tag, ".wdata"}, dmem_wdata, 32'd0);
      chk({tag, ".err"}, 32'(dmem_err), 32'd0);
      chk({tag, ".regwr"}, 32'(RegWriteM), 32'd0);
      chk({tag, ".m2r"}, 32'(MemtoRegM), 32'd0);
      chk({tag, ".alu"}, alu_outM, 32'd0);
      chk({tag, ".r3"}, 32'(r3_addrM), 32'd0);
      chk({tag, ".op"}, 32'(opM), 32'd0);
      chk({tag, ".dout"}, doutbM, 32'd0);
   endtask

   initial begin
      logic        rw, mtr, mw, vld, fl;
      logic [31:0] addr;
      int          kind;

      rst_n = 1'b0;
      RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; alu_outE = 0; write_dataE = 0;
      r3_addrE = 0; opE = 0; validE = 0; flushE = 0; dmem_rdata = 0; dmem_ack = 0;
      expDout = 32'd0;
      #1;
      chkAllZero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      doInstr(1, 0, 0, 32'h15, $urandom, 5'd3, 6'h20, 1, 0, 0, 32'd0, "add");
      doInstr(1, 1, 0, 32'h40, $urandom, 5'd5, 6'h23, 1, 0, 3, 32'hDEADBEEF, "load3");
      doInstr(0, 0, 1, 32'h44, 32'h12345678, 5'd0, 6'h2b, 1, 0, 1, $urandom, "store");
      doInstr(1, 1, 0, 32'h41, $urandom, 5'd6, 6'h23, 1, 0, 1, $urandom, "misal");
      doInstr(1, 1, 0, 32'h48, $urandom, 5'd7, 6'h23, 1, 0, 0, $urandom, "timeout");
      doInstr(1, 1, 0, 32'h4C, $urandom, 5'd8, 6'h23, 1, 0, 15, 32'hCAFEF00D, "ack15");
      doInstr(1, 0, 0, 32'h99, $urandom, 5'd9, 6'h20, 1, 1, 0, $urandom, "flush");
      doInstr(1, 1, 0, 32'h50, $urandom, 5'd10, 6'h23, 1, 1, 1, $urandom, "flushld");
      doInstr(1, 1, 0, 32'h54, $urandom, 5'd11, 6'h23, 0, 0, 1, $urandom, "invld");

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         rw  = (kind == 0) || (kind == 1) || ((kind == 3) && 1'($urandom));
         mtr = (kind == 1) || ((kind == 3) && 1'($urandom));
         mw  = (kind == 2) || ((kind == 3) && 1'($urandom));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         vld = ($urandom_range(0, 7) != 0);
         fl  = ($urandom_range(0, 7) == 0);
         doInstr(rw, mtr, mw, addr, $urandom, 5'($urandom), 6'($urandom), vld, fl,
                 $urandom_range(0, 16), $urandom, "rand");
      end

      // Reset in the middle of a BUSY window.
      @(negedge clk);
      RegWriteE = 1; MemtoRegE = 1; MemWriteE = 0; alu_outE = 32'h80; write_dataE = 0;
      r3_addrE = 5'd12; opE = 6'h23; validE = 1; flushE = 0; dmem_ack = 0;
      @(negedge clk);
      validE = 0; dmem_ack = 0;
      #1;
      chk("rstbusy.pre_stall", 32'(stallM), 32'd1);
      rst_n = 1'b0;
      #1;
      chkAllZero("rstbusy");
      expDout = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      driveIdle();
      @(negedge clk);
      driveIdle();
      #1;
      chk("rstrel.stall", 32'(stallM), 32'd0);
      chk("rstrel.req", 32'(dmem_req), 32'd0);
      chk("rstrel.dout", doutbM, expDout);

      doInstr(1, 0, 0, 32'h1234, $urandom, 5'd13, 6'h20, 1, 0, 0, 32'd0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_ctrl.md
EX_MEM_CTRL -- requirements
Module: ex_mem_ctrl

Interface
REQ-001 Reset is asynchronous and active-low; the block has one clock.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 RegWriteE, MemtoRegE, MemWriteE  in  1 each  EX-stage control bits.
REQ-005 alu_outE  in  32  EX result or memory address; write_dataE  in  32  store data.
REQ-006 r3_addrE  in  5  destination register; opE  in  6  opcode.
REQ-007 validE  in  1  EX holds a real instruction; flushE  in  1  kill the instruction being captured.
REQ-008 RegWriteM, MemtoRegM  out  1 each  control bits to MEM/WB.
REQ-009 alu_outM  out  32; r3_addrM  out  5; opM  out  6; doutbM  out  32 (load data).
REQ-010 stallM  out  1  freezes PC, IF/ID and ID/EX while high.
REQ-011 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32; dmem_rdata  in  32; dmem_ack  in  1.
REQ-012 dmem_err  out  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-013 When stallM=0, the stage register captures on each rising edge: valid = validE & ~flushE, plus all E-suffixed fields.
REQ-014 When stallM=1, the stage register holds its contents; flushE is ignored.
REQ-015 FSM states: IDLE and BUSY; stallM = (state==BUSY).
REQ-016 IDLE->BUSY on an edge that captures valid=1 with MemtoRegE|MemWriteE=1 and alu_outE[1:0]==0.
REQ-017 In BUSY: dmem_req=1, dmem_we=MemWrite_r, dmem_addr=alu_out_r, dmem_wdata=wdata_r; all four are 0 in IDLE.
REQ-018 BUSY->IDLE on the edge where dmem_ack=1; dmem_rdata is latched into doutbM on that edge.
REQ-019 Timeout: a 4-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
REQ-020 The cycle the counter reaches 15 without ack: dmem_err=1; next edge -> IDLE with the instruction killed (valid cleared).
REQ-021 Misaligned access: a captured memory op with alu_outE[1:0]!=0 issues no request and stays in IDLE.
REQ-022 Misaligned access: dmem_err=1 for the following cycle and valid is cleared.
REQ-023 RegWriteM = RegWrite_r & valid & (state==IDLE); MemtoRegM likewise gated; BUSY presents a bubble.
REQ-024 alu_outM, r3_addrM and opM reflect the stage register directly; doutbM holds until the next ack.
REQ-025 Latency, non-memory op: captured at edge N, presented to MEM/WB during cycle N..N+1.
REQ-026 Latency, memory op with ack on the first BUSY cycle: results presented one cycle after the ack edge; stallM high for exactly one cycle.
REQ-027 An ack arriving in IDLE is ignored.
REQ-028 A simultaneous ack and timeout-15 cycle counts as ack, with no error.

Reset
REQ-029 Reset forces state=IDLE, valid=0, counter=0.
REQ-030 Reset forces all outputs to 0: stallM, dmem_*, dmem_err, RegWriteM, MemtoRegM, alu_outM, r3_addrM, opM, doutbM.
REQ-031 Reset asserted while BUSY abandons the access immediately; dmem_req drops asynchronously.

Verification
REQ-032 Add op, validE=1, alu_outE=0x15, r3_addrE=3, RegWriteE=1 -> next cycle RegWriteM=1, alu_outM=0x15, stallM=0.
REQ-033 Load at addr 0x40, ack on 3rd BUSY cycle with rdata=0xDEADBEEF -> stallM high 3 cycles, RegWriteM=0 meanwhile; then doutbM=0xDEADBEEF, MemtoRegM=1.
REQ-034 Store at 0x44, write_dataE=0x12345678, ack immediate -> one cycle with dmem_req=1, dmem_we=1, dmem_wdata=0x12345678; RegWriteM=0.
REQ-035 Load at 0x41 -> no dmem_req; dmem_err pulse 1 cycle; RegWriteM=0.
REQ-036 Load, never acked -> dmem_err on the 15th BUSY cycle, then IDLE, stallM=0, RegWriteM=0.
REQ-037 flushE=1 with validE=1 -> bubble; rst_n low mid-BUSY -> all outputs 0 at once, state IDLE after release.
